mmp_iddmm_arb: RTL and testbench
================================

MMP_IDDMM_ARB -- requirements
Module: mmp_iddmm_arb

Interface
REQ-001 The block SHALL have parameter K, default 128, giving the operand word width in bits.
REQ-002 The block SHALL have parameter N, default 16, giving the number of words per operand.
REQ-003 The block SHALL have parameter ADDR_W, default $clog2(N), giving the word address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req, input, 2 bits: per-requester level request.
REQ-007 The block SHALL have port gnt, output, 2 bits: one-hot grant.
REQ-008 The block SHALL have port start, input, 2 bits: per-requester start pulse.
REQ-009 The block SHALL have port ld_ena, input, 6 bits: requester r uses bits [3r+2:3r] as {m,y,x} write enables.
REQ-010 The block SHALL have port ld_addr, input, 2*ADDR_W bits: packed per-requester word address.
REQ-011 The block SHALL have ports ld_x, ld_y, ld_m and ld_m1, each input, 2*K bits: packed per-requester operand words.
REQ-012 The block SHALL have ports mm_wr_ena (output, 3 bits), mm_wr_addr (output, ADDR_W bits), and mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1 (each output, K bits): load interface to the multiplier.
REQ-013 The block SHALL have port mm_task_req, output, 1 bit: start pulse to the multiplier.
REQ-014 The block SHALL have ports mm_task_end (input, 1 bit), mm_task_grant (input, 1 bit) and mm_task_res (input, K bits): result interface from the multiplier.
REQ-015 The block SHALL have ports res_val (output, 2 bits), res_last (output, 2 bits) and res_data (output, K bits): result stream to the requesters.
REQ-016 The block SHALL have port busy, output, 1 bit: asserted whenever the state is not IDLE.

Function
REQ-017 The state machine SHALL have four states, IDLE, LOAD, RUN and DONE, with gnt registered.
REQ-018 In IDLE, when req is non-zero, the block SHALL register a one-hot gnt and go to LOAD. If both requesters request, the one not served last wins.
REQ-019 In LOAD, mm_wr_* SHALL be a combinational mux of the granted requester's ld_* fields. The other requester's ld_ena SHALL be ignored.
REQ-020 mm_wr_ena SHALL be 0 in every state except LOAD.
REQ-021 In LOAD, when start[g] is high, the block SHALL go to RUN and drive mm_task_req high for exactly the next cycle. A write on the same cycle as start SHALL still pass through.
REQ-022 In LOAD, if req[g] falls without start[g], the block SHALL clear gnt and return to IDLE without updating the round-robin pointer.
REQ-023 In RUN, res_val[g] SHALL equal mm_task_grant and res_data SHALL equal mm_task_res, both delayed by exactly one register stage. res_val of the non-granted requester SHALL remain 0.
REQ-024 res_last[g] SHALL be mm_task_end delayed by one register stage. On mm_task_end the block SHALL go to DONE.
REQ-025 Deassertion of req[g] during RUN SHALL be ignored: the task completes and all results are delivered.
REQ-026 start of the non-granted requester, and any start in IDLE, RUN or DONE, SHALL be ignored.
REQ-027 DONE SHALL last exactly one cycle, clear gnt, set the round-robin pointer to g, and return to IDLE. A new grant is therefore possible no earlier than two cycles after mm_task_end.

Reset
REQ-028 While rst_n is low, the block SHALL force state IDLE and set the pointer so that requester 0 wins a tie.
REQ-029 While rst_n is low, gnt, mm_wr_ena, mm_task_req, res_val, res_last, busy and err (when present) SHALL all be 0.
REQ-030 While rst_n is low, mm_wr_addr, all data outputs and res_data SHALL be 0.
REQ-031 Reset asserted mid-LOAD or mid-RUN SHALL abort immediately; results still arriving after release SHALL be discarded.

Configuration
REQ-032 With macro MMP_IDDMM_ARB_TIMEOUT_EN defined, the block SHALL have output port err, 1 bit, and a 12-bit watchdog counter.
REQ-033 With MMP_IDDMM_ARB_TIMEOUT_EN defined, the watchdog SHALL clear on mm_task_req and count every RUN cycle.
REQ-034 With MMP_IDDMM_ARB_TIMEOUT_EN defined, if the count reaches 4095 without mm_task_end, the block SHALL set err and go to DONE.
REQ-035 With MMP_IDDMM_ARB_TIMEOUT_EN defined, err SHALL be sticky until the next grant.
REQ-036 Without MMP_IDDMM_ARB_TIMEOUT_EN, there SHALL be no err port and no counter, and RUN SHALL wait indefinitely.

Verification
REQ-037 Single requester: req=01, 16 words loaded with ld_x0=i, then start[0] -> gnt=01 one cycle after req, exactly one mm_task_req pulse, 16 res_val[0] pulses, res_last[0] on the last pulse, gnt=00 after DONE.
REQ-038 Contention: req=11 from reset, with the same flow repeated -> requester 0 served first, then requester 1, then requester 0 again.
REQ-039 Isolation: ld_ena=6'b111_000 while gnt=01 -> mm_wr_ena stays 3'b000.
REQ-040 Abort and drop: req[0] dropped in LOAD -> IDLE with no mm_task_req. req[0] dropped in RUN -> all 16 results still delivered.
REQ-041 Mid-run reset: rst_n pulsed low in RUN -> all outputs 0 within the same cycle, and no res_val after release.
REQ-042 With MMP_IDDMM_ARB_TIMEOUT_EN: mm_task_end withheld -> err=1 after 4095 RUN cycles, gnt cleared, err cleared on the next grant.

Source files
------------

// File: rtl/mmp_iddmm_arb.sv
// mmp_iddmm_arb: two-requester round-robin front end for one IDDMM multiplier.
// The granted requester loads operands through a combinational mux, starts a
// task, and receives the result stream back one register stage later.
// Optional build macro MMP_IDDMM_ARB_TIMEOUT_EN adds a 12-bit RUN watchdog and
// a sticky err output.
module mmp_iddmm_arb #(
    parameter int K      = 128,
    parameter int N      = 16,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    output logic [1:0]          gnt,
    input  logic [1:0]          start,
    input  logic [5:0]          ld_ena,
    input  logic [2*ADDR_W-1:0] ld_addr,
    input  logic [2*K-1:0]      ld_x,
    input  logic [2*K-1:0]      ld_y,
    input  logic [2*K-1:0]      ld_m,
    input  logic [2*K-1:0]      ld_m1,
    output logic [2:0]          mm_wr_ena,
    output logic [ADDR_W-1:0]   mm_wr_addr,
    output logic [K-1:0]        mm_wr_x,
    output logic [K-1:0]        mm_wr_y,
    output logic [K-1:0]        mm_wr_m,
    output logic [K-1:0]        mm_wr_m1,
    output logic                mm_task_req,
    input  logic                mm_task_end,
    input  logic                mm_task_grant,
    input  logic [K-1:0]        mm_task_res,
    output logic [1:0]          res_val,
    output logic [1:0]          res_last,
    output logic [K-1:0]        res_data,
`ifdef MMP_IDDMM_ARB_TIMEOUT_EN
    output logic                err,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_gnt, w_gnt_nxt;
    logic       r_ptr, w_ptr_nxt;       // index of the requester served last
    logic       r_task_req, w_task_req_nxt;
    logic [1:0] r_res_val, r_res_last;
    logic [K-1:0] r_res_data;

    logic w_g;          // index of the granted requester
    logic w_req_g;
    logic w_start_g;
    logic w_in_load;
    logic w_in_run;

`ifdef MMP_IDDMM_ARB_TIMEOUT_EN
    logic [11:0] r_wdog, w_wdog_nxt, w_wdog_inc;
    logic        r_err, w_err_nxt;
`endif

    assign w_g       = r_gnt[1];
    assign w_req_g   = w_g ? req[1]   : req[0];
    assign w_start_g = w_g ? start[1] : start[0];
    assign w_in_load = (r_state == S_LOAD);
    assign w_in_run  = (r_state == S_RUN);

    // State, grant, round-robin pointer and task-start pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= 2'b00;
            r_ptr      <= 1'b1;     // "last served = 1" lets requester 0 win the first tie
            r_task_req <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ptr      <= w_ptr_nxt;
            r_task_req <= w_task_req_nxt;
        end
    end

    // Next-state logic: arbitration, load/start, run completion, done cleanup
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_ptr_nxt      = r_ptr;
        w_task_req_nxt = 1'b0;
`ifdef MMP_IDDMM_ARB_TIMEOUT_EN
        w_wdog_inc = r_wdog + 12'd1;
        w_wdog_nxt = r_wdog;
        w_err_nxt  = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    w_state_nxt = S_LOAD;
                    if (req == 2'b11) w_gnt_nxt = r_ptr ? 2'b01 : 2'b10;
                    else              w_gnt_nxt = req;
`ifdef MMP_IDDMM_ARB_TIMEOUT_EN
                    w_err_nxt = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (w_start_g) begin
                    w_state_nxt    = S_RUN;
                    w_task_req_nxt = 1'b1;
`ifdef MMP_IDDMM_ARB_TIMEOUT_EN
                    w_wdog_nxt = 12'd0;
`endif
                end else if (!w_req_g) begin
                    // Abandoned load: back to IDLE, pointer untouched
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = 2'b00;
                end
            end
            S_RUN: begin
                if (mm_task_end) begin
                    w_state_nxt = S_DONE;
                end
`ifdef MMP_IDDMM_ARB_TIMEOUT_EN
                else if (w_wdog_inc == 12'hFFF) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                    w_wdog_nxt  = w_wdog_inc;
                end else begin
                    w_wdog_nxt = w_wdog_inc;
                end
`endif
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 2'b00;
                w_ptr_nxt   = w_g;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 2'b00;
            end
        endcase
    end

`ifdef MMP_IDDMM_ARB_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= 12'd0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= w_wdog_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign err = r_err;
`endif

    // Load mux: only the granted requester reaches the multiplier, only in LOAD
    always_comb begin
        mm_wr_ena  = 3'b000;
        mm_wr_addr = '0;
        mm_wr_x    = '0;
        mm_wr_y    = '0;
        mm_wr_m    = '0;
        mm_wr_m1   = '0;
        if (w_in_load) begin
            mm_wr_ena  = w_g ? ld_ena[5:3]                  : ld_ena[2:0];
            mm_wr_addr = w_g ? ld_addr[2*ADDR_W-1:ADDR_W]   : ld_addr[ADDR_W-1:0];
            mm_wr_x    = w_g ? ld_x[2*K-1:K]                : ld_x[K-1:0];
            mm_wr_y    = w_g ? ld_y[2*K-1:K]                : ld_y[K-1:0];
            mm_wr_m    = w_g ? ld_m[2*K-1:K]                : ld_m[K-1:0];
            mm_wr_m1   = w_g ? ld_m1[2*K-1:K]               : ld_m1[K-1:0];
        end
    end

    // Result stage: multiplier outputs steered to the granted requester, RUN only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_val  <= 2'b00;
            r_res_last <= 2'b00;
            r_res_data <= '0;
        end else if (w_in_run) begin
            r_res_val  <= r_gnt & {2{mm_task_grant}};
            r_res_last <= r_gnt & {2{mm_task_end}};
            r_res_data <= mm_task_res;
        end else begin
            r_res_val  <= 2'b00;
            r_res_last <= 2'b00;
            r_res_data <= '0;
        end
    end

    assign gnt         = r_gnt;
    assign mm_task_req = r_task_req;
    assign res_val     = r_res_val;
    assign res_last    = r_res_last;
    assign res_data    = r_res_data;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mmp_iddmm_arb.sv
// tb_mmp_iddmm_arb: directed bench for mmp_iddmm_arb with a result scoreboard.
// Build with MMP_IDDMM_ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_mmp_iddmm_arb;

    localparam int K  = 128;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req, gnt, start;
    logic [5:0]    ld_ena;
    logic [2*AW-1:0] ld_addr;
    logic [2*K-1:0] ld_x, ld_y, ld_m, ld_m1;
    logic [2:0]    mm_wr_ena;
    logic [AW-1:0] mm_wr_addr;
    logic [K-1:0]  mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1;
    logic          mm_task_req, mm_task_end, mm_task_grant;
    logic [K-1:0]  mm_task_res;
    logic [1:0]    res_val, res_last;
    logic [K-1:0]  res_data;
    logic          busy;
`ifdef MMP_IDDMM_ARB_TIMEOUT_EN
    logic          err;
`endif

    mmp_iddmm_arb #(.K(K), .N(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .start(start),
        .ld_ena(ld_ena), .ld_addr(ld_addr), .ld_x(ld_x), .ld_y(ld_y),
        .ld_m(ld_m), .ld_m1(ld_m1), .mm_wr_ena(mm_wr_ena), .mm_wr_addr(mm_wr_addr),
        .mm_wr_x(mm_wr_x), .mm_wr_y(mm_wr_y), .mm_wr_m(mm_wr_m), .mm_wr_m1(mm_wr_m1),
        .mm_task_req(mm_task_req), .mm_task_end(mm_task_end),
        .mm_task_grant(mm_task_grant), .mm_task_res(mm_task_res),
        .res_val(res_val), .res_last(res_last), .res_data(res_data),
`ifdef MMP_IDDMM_ARB_TIMEOUT_EN
        .err(err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   who;
        logic         last;
        logic [K-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   trq_cnt = 0;

    task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts task-start pulses and checks each presented result against the scoreboard
    always @(negedge clk) begin
        if (mm_task_req === 1'b1) trq_cnt++;
        if (res_val !== 2'b00) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got res_val=%b expected none at %0t", res_val, $time);
            end else begin
                mon_e = sb.pop_front();
                check("res_val",  K'(res_val), K'(mon_e.who));
                check("res_last", K'(res_last), mon_e.last ? K'(mon_e.who) : K'(0));
                check("res_data", res_data, mon_e.data);
            end
        end
    end

    // Waits (bounded) for a non-zero grant and checks it; returns cycles waited
    task automatic wait_gnt(input logic [1:0] exp, output int cyc);
        cyc = 0;
        @(negedge clk);
        while (gnt == 2'b00 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("gnt", K'(gnt), K'(exp));
    endtask

    // Loads 16 words for requester r (other requester drives conflicting junk), start on last word
    task automatic load_and_start(input int r);
        for (int i = 0; i < 16; i++) begin
            ld_ena = 6'b0;
            ld_ena[3*r +: 3]        = 3'b111;
            ld_ena[3*(1-r) +: 3]    = 3'b010;
            ld_addr[AW*r +: AW]     = AW'(i);
            ld_addr[AW*(1-r) +: AW] = AW'(15 - i);
            ld_x[K*r +: K]          = K'(i);
            ld_x[K*(1-r) +: K]      = K'(32'hdead);
            ld_y[K*r +: K]          = K'(i + 32);
            ld_m[K*r +: K]          = K'(i + 64);
            ld_m1[K*r +: K]         = K'(99);
            start = 2'b00;
            if (i == 15) start[r] = 1'b1;
            #1;
            check("wr_ena",  K'(mm_wr_ena), K'(3'b111));
            check("wr_addr", K'(mm_wr_addr), K'(i));
            check("wr_x",    mm_wr_x, K'(i));
            check("wr_y",    mm_wr_y, K'(i + 32));
            check("wr_m",    mm_wr_m, K'(i + 64));
            check("wr_m1",   mm_wr_m1, K'(99));
            @(posedge clk); #1;
        end
        ld_ena = 6'b0;
        start  = 2'b00;
        ld_x = '0; ld_y = '0; ld_m = '0; ld_m1 = '0; ld_addr = '0;
    endtask

    // One full transaction for requester r; optionally drops req[r] during RUN
    task automatic serve(input int r, input logic drop, input logic chk_latency);
        int cyc;
        int trq0;
        logic [K-1:0] v;
        wait_gnt(2'(1 << r), cyc);
        if (chk_latency) check("gnt_latency", K'(cyc), K'(1));
        check("busy_load", K'(busy), K'(1));
        trq0 = trq_cnt;
        load_and_start(r);
        @(negedge clk);
        check("task_req_pulse", K'(mm_task_req), K'(1));
        for (int i = 0; i < 16; i++) begin
            v = K'((r + 1) * 4096 + i * 3 + 1);
            mm_task_grant = 1'b1;
            mm_task_res   = v;
            mm_task_end   = (i == 15);
            sb.push_back('{2'(1 << r), (i == 15), v});
            if (drop && i == 5) req[r] = 1'b0;
            @(posedge clk); #1;
        end
        mm_task_grant = 1'b0;
        mm_task_end   = 1'b0;
        mm_task_res   = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("gnt_after_done", K'(gnt), K'(0));
        check("busy_after_done", K'(busy), K'(0));
        check("task_req_count", K'(trq_cnt - trq0), K'(1));
        check("sb_drained", K'(sb.size()), K'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc;
        int trq0;
        // Reset with busy-looking inputs: everything must read zero
        rst_n = 1'b0;
        req = 2'b11; start = 2'b11; ld_ena = 6'h3f;
        ld_addr = '1; ld_x = '1; ld_y = '1; ld_m = '1; ld_m1 = '1;
        mm_task_end = 1'b1; mm_task_grant = 1'b1; mm_task_res = '1;
        #22;
        check("rst_gnt",      K'(gnt), K'(0));
        check("rst_busy",     K'(busy), K'(0));
        check("rst_task_req", K'(mm_task_req), K'(0));
        check("rst_wr_ena",   K'(mm_wr_ena), K'(0));
        check("rst_wr_addr",  K'(mm_wr_addr), K'(0));
        check("rst_wr_x",     mm_wr_x, K'(0));
        check("rst_res_val",  K'(res_val), K'(0));
        check("rst_res_last", K'(res_last), K'(0));
        check("rst_res_data", res_data, K'(0));
        req = 2'b00; start = 2'b00; ld_ena = 6'b0;
        ld_addr = '0; ld_x = '0; ld_y = '0; ld_m = '0; ld_m1 = '0;
        mm_task_end = 1'b0; mm_task_grant = 1'b0; mm_task_res = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single requester
        req = 2'b01;
        serve(0, 1'b0, 1'b1);
        req = 2'b00;

        // Contention from reset: 0, then 1, then 0
        @(negedge clk);
        rst_n = 1'b0;
        req   = 2'b11;
        @(posedge clk); #1;
        rst_n = 1'b1;
        serve(0, 1'b0, 1'b0);
        serve(1, 1'b0, 1'b0);
        serve(0, 1'b0, 1'b0);
        req = 2'b00;

        // Abort in LOAD for requester 1; foreign ld_ena and foreign start ignored
        @(negedge clk);
        trq0 = trq_cnt;
        req = 2'b10;
        wait_gnt(2'b10, cyc);
        ld_ena = 6'b000_111;
        start  = 2'b01;
        #1;
        check("iso_wr_ena_g1", K'(mm_wr_ena), K'(0));
        @(negedge clk);
        check("foreign_start_gnt", K'(gnt), K'(2'b10));
        check("foreign_start_treq", K'(mm_task_req), K'(0));
        req = 2'b00; start = 2'b00; ld_ena = 6'b0;
        @(negedge clk);
        check("abort_gnt",  K'(gnt), K'(0));
        check("abort_busy", K'(busy), K'(0));
        check("abort_no_treq", K'(trq_cnt - trq0), K'(0));

        // Pointer untouched by the abort: requester 1 wins the tie; drop req[1] in RUN
        req = 2'b11;
        serve(1, 1'b1, 1'b0);

        // Mid-run reset with requester 0 (still requesting)
        wait_gnt(2'b01, cyc);
        ld_ena = 6'b111_000;
        #1;
        check("iso_wr_ena_g0", K'(mm_wr_ena), K'(0));
        ld_ena = 6'b0;
        @(posedge clk); #1;
        start = 2'b01;
        @(posedge clk); #1;
        start = 2'b00;
        @(negedge clk);
        check("mr_task_req", K'(mm_task_req), K'(1));
        for (int i = 0; i < 2; i++) begin
            mm_task_grant = 1'b1;
            mm_task_res   = K'(16'h7700 + i);
            sb.push_back('{2'b01, 1'b0, K'(16'h7700 + i)});
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        req = 2'b00;
        mm_task_res = K'(16'hbad0);
        #1;
        check("mr_gnt",      K'(gnt), K'(0));
        check("mr_busy",     K'(busy), K'(0));
        check("mr_res_val",  K'(res_val), K'(0));
        check("mr_res_last", K'(res_last), K'(0));
        check("mr_res_data", res_data, K'(0));
        check("mr_task_req_rst", K'(mm_task_req), K'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        mm_task_grant = 1'b0;
        mm_task_res   = '0;
        @(negedge clk);
        check("mr_busy_after", K'(busy), K'(0));
        check("mr_sb_drained", K'(sb.size()), K'(0));

`ifdef MMP_IDDMM_ARB_TIMEOUT_EN
        // Watchdog: end withheld, err after 4095 RUN cycles, cleared by the next grant
        req = 2'b01;
        wait_gnt(2'b01, cyc);
        start = 2'b01;
        @(posedge clk); #1;
        start = 2'b00;
        cyc = 0;
        @(negedge clk);
        while (err !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("wd_err", K'(err), K'(1));
        check("wd_cycles", K'(cyc >= 4090 && cyc <= 4098), K'(1));
        @(negedge clk);
        check("wd_gnt_cleared", K'(gnt), K'(0));
        check("wd_err_sticky", K'(err), K'(1));
        @(negedge clk);
        check("wd_regrant", K'(gnt), K'(2'b01));
        check("wd_err_cleared", K'(err), K'(0));
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
